dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 119 +++++++++++
 tb/tb_dma_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// Page DMA controller: a CPU write to DMA_REG copies 256 bytes to DEST_ADDR.
// Optional completion pulse on dma_done when DMA_DONE_PULSE_EN is defined.
module dma_ctrl #(
  parameter logic [15:0] DMA_REG   = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_wr_enable,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_rdy,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wr_enable,
  input  logic [7:0]  mem_rd_data,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     r_state;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_data_q;
  logic       w_trig;

  assign w_trig = resetn & (r_state == S_IDLE) &
                  cpu_wr_enable & (cpu_address == DMA_REG);

  assign cpu_rd_data = mem_rd_data;
  assign cpu_rdy     = (r_state == S_IDLE);
  assign dma_busy    = ~cpu_rdy;

  // Memory bus mux: CPU pass-through in IDLE, DMA-driven otherwise
  always_comb begin
    mem_address   = cpu_address;
    mem_wr_data   = cpu_wr_data;
    mem_wr_enable = cpu_wr_enable & ~w_trig;
    unique case (r_state)
      S_IDLE: ;
      S_ALIGN: begin
        mem_address   = 16'h0000;
        mem_wr_data   = 8'h00;
        mem_wr_enable = 1'b0;
      end
      S_READ: begin
        mem_address   = {r_page, r_idx};
        mem_wr_data   = 8'h00;
        mem_wr_enable = 1'b0;
      end
      S_WRITE: begin
        mem_address   = DEST_ADDR;
        mem_wr_data   = r_data_q;
        mem_wr_enable = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer sequencer: ALIGN once, then READ/WRITE pairs for idx 0..255
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_data_q <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_page  <= cpu_wr_data;
            r_idx   <= 8'h00;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: r_state <= S_READ;
        S_READ: begin
          r_data_q <= mem_rd_data;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          if (r_idx != 8'hFF) begin
            r_idx   <= r_idx + 8'h01;
            r_state <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DMA_DONE_PULSE_EN
  logic r_done;

  // One-cycle pulse in the first IDLE cycle after the final write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_WRITE) && (r_idx == 8'hFF);
    end
  end

  assign dma_done = r_done;
`else
  assign dma_done = 1'b0;
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: vector table, directed and random DMAs.
// Expected bus activity is derived from a snapshot of the source page.
module tb_dma_ctrl;

  localparam logic [15:0] DMA_REG   = 16'h4014;
  localparam logic [15:0] DEST_ADDR = 16'h2004;

  logic        clk;
  logic        resetn;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rdy;
  logic [15:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_enable;
  logic [7:0]  mem_rd_data;
  logic        dma_busy;
  logic        dma_done;

  logic [7:0]  mem [0:65535];

  int n_chk;
  int n_fail;

  dma_ctrl #(
    .DMA_REG  (DMA_REG),
    .DEST_ADDR(DEST_ADDR)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_address  (cpu_address),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_enable(cpu_wr_enable),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rdy      (cpu_rdy),
    .mem_address  (mem_address),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_enable(mem_wr_enable),
    .mem_rd_data  (mem_rd_data),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_address] <= mem_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic done_exp_at_end();
`ifdef DMA_DONE_PULSE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wen;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_wen;
  } vec_t;

  vec_t vecs [8];

  // Runs one page transfer; abort_j >= 0 asserts reset at that write index
  task automatic run_dma(input logic [7:0] page, input int abort_j);
    logic [7:0] exp_q [$];
    int j;
    exp_q = {};
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[{page, i[7:0]}]);
    @(negedge clk);
    cpu_address   = DMA_REG;
    cpu_wr_data   = page;
    cpu_wr_enable = 1'b1;
    #1;
    chk("trig_not_fwd", {31'd0, mem_wr_enable}, 32'd0);
    chk("trig_rdy", {31'd0, cpu_rdy}, 32'd1);
    for (int k = 1; k <= 513; k++) begin
      @(negedge clk);
      cpu_address   = (k % 7 == 0) ? DMA_REG : 16'($urandom);
      cpu_wr_data   = 8'($urandom);
      cpu_wr_enable = (k % 7 == 0) ? 1'b1 : 1'($urandom);
      #1;
      chk("busy_rdy", {31'd0, cpu_rdy}, 32'd0);
      chk("busy_flag", {31'd0, dma_busy}, 32'd1);
      chk("busy_done", {31'd0, dma_done}, 32'd0);
      chk("rd_pass", {24'd0, cpu_rd_data}, {24'd0, mem[mem_address]});
      if (k == 1) begin
        chk("align_addr", {16'd0, mem_address}, 32'h0);
        chk("align_wen", {31'd0, mem_wr_enable}, 32'd0);
        chk("align_wd", {24'd0, mem_wr_data}, 32'd0);
      end else begin
        j = (k - 2) / 2;
        if (k % 2 == 0) begin
          chk("rd_addr", {16'd0, mem_address}, {16'd0, page, 8'(j)});
          chk("rd_wen", {31'd0, mem_wr_enable}, 32'd0);
        end else begin
          chk("wr_addr", {16'd0, mem_address}, {16'd0, DEST_ADDR});
          chk("wr_wen", {31'd0, mem_wr_enable}, 32'd1);
          chk("wr_data", {24'd0, mem_wr_data}, {24'd0, exp_q[j]});
          if (j == abort_j) begin
            resetn = 1'b0;
            #1;
            chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
            chk("rst_busy", {31'd0, dma_busy}, 32'd0);
            chk("rst_done", {31'd0, dma_done}, 32'd0);
            cpu_address   = 16'h0500;
            cpu_wr_data   = 8'h77;
            cpu_wr_enable = 1'b1;
            #1;
            chk("rst_pass_a", {16'd0, mem_address}, 32'h0500);
            chk("rst_pass_w", {31'd0, mem_wr_enable}, 32'd1);
            chk("rst_pass_d", {24'd0, mem_wr_data}, 32'h77);
            @(negedge clk);
            cpu_wr_enable = 1'b0;
            @(negedge clk);
            #1;
            chk("rst_hold_rdy", {31'd0, cpu_rdy}, 32'd1);
            resetn = 1'b1;
            return;
          end
        end
      end
    end
    @(negedge clk);
    cpu_address   = 16'h0100;
    cpu_wr_data   = 8'h00;
    cpu_wr_enable = 1'b0;
    #1;
    chk("end_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("end_busy", {31'd0, dma_busy}, 32'd0);
    chk("end_done", {31'd0, dma_done}, {31'd0, done_exp_at_end()});
    chk("end_dest", {24'd0, mem[DEST_ADDR]}, {24'd0, exp_q[255]});
    @(negedge clk);
    #1;
    chk("post_done", {31'd0, dma_done}, 32'd0);
    chk("post_rdy", {31'd0, cpu_rdy}, 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    vecs[0] = '{16'h0200, 8'h5A, 1'b1, 16'h0200, 8'h5A, 1'b1};
    vecs[1] = '{16'h1234, 8'h00, 1'b0, 16'h1234, 8'h00, 1'b0};
    vecs[2] = '{DMA_REG,  8'h33, 1'b0, DMA_REG,  8'h33, 1'b0};
    vecs[3] = '{16'h4015, 8'h11, 1'b1, 16'h4015, 8'h11, 1'b1};
    vecs[4] = '{DEST_ADDR,8'hFF, 1'b1, DEST_ADDR,8'hFF, 1'b1};
    vecs[5] = '{16'hFFFF, 8'hAA, 1'b1, 16'hFFFF, 8'hAA, 1'b1};
    vecs[6] = '{16'h0000, 8'h01, 1'b1, 16'h0000, 8'h01, 1'b1};
    vecs[7] = '{16'h4013, 8'h9C, 1'b1, 16'h4013, 8'h9C, 1'b1};

    resetn        = 1'b0;
    cpu_address   = 16'h0000;
    cpu_wr_data   = 8'h00;
    cpu_wr_enable = 1'b0;
    #1;
    chk("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("reset_busy", {31'd0, dma_busy}, 32'd0);
    chk("reset_done", {31'd0, dma_done}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[v]) begin
      @(negedge clk);
      cpu_address   = vecs[v].addr;
      cpu_wr_data   = vecs[v].wdata;
      cpu_wr_enable = vecs[v].wen;
      #1;
      chk("vec_addr", {16'd0, mem_address}, {16'd0, vecs[v].e_addr});
      chk("vec_wd", {24'd0, mem_wr_data}, {24'd0, vecs[v].e_wdata});
      chk("vec_wen", {31'd0, mem_wr_enable}, {31'd0, vecs[v].e_wen});
      chk("vec_rdy", {31'd0, cpu_rdy}, 32'd1);
      chk("vec_rd", {24'd0, cpu_rd_data}, {24'd0, mem[mem_address]});
    end
    @(negedge clk);
    cpu_wr_enable = 1'b0;
    #1;
    chk("dmareg_read_nodma", {31'd0, cpu_rdy}, 32'd1);

    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
    run_dma(8'h03, -1);

    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'($urandom);
    mem[16'h0000] = 8'hEE;
    run_dma(8'hFF, -1);

    for (int i = 0; i < 256; i++) mem[16'h0400 + i] = 8'($urandom);
    run_dma(8'h04, 100);
    run_dma(8'h04, -1);

    for (int r = 0; r < 3; r++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      if (pg == DEST_ADDR[15:8]) pg = pg + 8'h01;
      for (int i = 0; i < 256; i++) mem[{pg, i[7:0]}] = 8'($urandom);
      run_dma(pg, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
